data_memory_responder: RTL and testbench
========================================

DATA_MEMORY_RESPONDER -- requirements
Module: data_memory_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024: number of 32-bit words in storage (power of two).
REQ-002 SHALL have parameter READ_LATENCY, default 2: cycles from request acceptance to rsp_valid_o, legal range 1..4.
REQ-003 SHALL have port clk_i  input  1: single clock; all logic on rising edge.
REQ-004 SHALL have port rst_i  input  1: reset, synchronous, active-high.
REQ-005 SHALL have port req_valid_i  input  1: request present.
REQ-006 SHALL have port req_ready_o  output  1: responder can accept a request.
REQ-007 SHALL have port req_write_i  input  1: 1 = store, 0 = load.
REQ-008 SHALL have port req_byte_en_i  input  4: per-byte write strobes, already lane-shifted by the requester.
REQ-009 SHALL have port req_address_i  input  32: byte address; word index = address[31:2].
REQ-010 SHALL have port req_wdata_i  input  32: store data, already lane-aligned.
REQ-011 SHALL have port rsp_valid_o  output  1: response present.
REQ-012 SHALL have port rsp_ready_i  input  1: requester accepts response.
REQ-013 SHALL have port rsp_rdata_o  output  32: full stored word, no lane extraction or extension.
REQ-014 SHALL have port rsp_error_o  output  1: access out of range; valid only with rsp_valid_o.

Function
REQ-015 SHALL implement FSM states IDLE, WAIT, RESP; req_ready_o = 1 only in IDLE.
REQ-016 SHALL accept a request on a rising edge with req_valid_i & req_ready_o and register write, byte_en, address, wdata.
REQ-017 SHALL transition IDLE->WAIT on acceptance, load the latency counter with READ_LATENCY-1, and decrement it each WAIT cycle.
REQ-018 SHALL transition WAIT->RESP when the counter is 0, so that rsp_valid_o rises exactly READ_LATENCY cycles after the acceptance edge. With READ_LATENCY=1, WAIT lasts zero cycles (IDLE->RESP directly).
REQ-019 SHALL, for an in-range store, write only bytes whose byte_en bit is 1, on the acceptance edge. Non-contiguous strobe patterns are legal. byte_en = 0000 writes nothing.
REQ-020 SHALL ignore req_byte_en_i for loads and return the whole word.
REQ-021 SHALL return, for a store, rsp_rdata_o equal to the word after the write (read-after-write).
REQ-022 SHALL treat a word index >= DEPTH_WORDS as out of range: no write, rsp_rdata_o = 0, rsp_error_o = 1.
REQ-023 SHALL hold rsp_valid_o, rsp_rdata_o and rsp_error_o stable in RESP until rsp_ready_i = 1.
REQ-024 SHALL go RESP->IDLE on the rsp handshake edge, giving a one-cycle bubble between responses; one outstanding request maximum.
REQ-025 SHALL drive rsp_rdata_o = 0 and rsp_error_o = 0 whenever rsp_valid_o = 0.
REQ-026 SHALL ignore req_* inputs while not in IDLE. A requester holding req_valid_i is accepted on the first IDLE cycle.
REQ-027 SHALL ignore address bits [1:0]; alignment is the requester's responsibility.

Reset
REQ-028 SHALL, when rst_i = 1 on a rising edge, enter IDLE with counter = 0, req_ready_o = 0 during that reset cycle and 1 afterwards, and rsp_valid_o = 0, rsp_rdata_o = 0, rsp_error_o = 0.
REQ-029 SHALL, on reset mid-operation (WAIT or RESP), drop the in-flight response. A store already accepted remains written. Storage contents are not cleared by reset.
REQ-030 SHALL give rst_i priority over a coincident request or response handshake.

Structure
REQ-031 SHALL place the FSM state enum, the byte-lane count constant (4) and the latency-range constants in shared package mem_pkg.
REQ-032 SHALL instantiate one sub-module, byte_write_ram: single-port, DEPTH_WORDS x 32, 4 byte write enables, synchronous write, combinational-or-registered read hidden behind the latency counter.

Verification
REQ-033 Load/store: store 0xDEADBEEF to 0x10 with byte_en 1111, then load 0x10 -> rsp_rdata_o = 0xDEADBEEF, error 0, rsp_valid_o exactly 2 cycles after each acceptance.
REQ-034 Byte strobes: word 0x11223344 at 0x20, then store wdata 0xAA00BB00 with byte_en 1010 -> subsequent load returns 0xAA22BB44.
REQ-035 Backpressure: hold rsp_ready_i = 0 for 5 cycles in RESP -> rsp_valid_o and data stay stable, req_ready_o stays 0, and a second request is accepted only after the handshake plus one bubble.
REQ-036 Out of range: DEPTH_WORDS = 1024, store to 0x1000 -> rsp_error_o = 1, rdata 0. A load from 0x0 is unchanged.
REQ-037 Reset mid-op: assert rst_i for 1 cycle during WAIT of a store to 0x30 -> no response issued, IDLE afterwards, and a load from 0x30 returns the stored value.
REQ-038 Latency sweep: READ_LATENCY = 1 and 4 -> response appears 1 and 4 cycles after acceptance respectively.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types and constants for the data memory responder and its storage.
package mem_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam int BYTE_LANES       = 4;
  localparam int MIN_READ_LATENCY = 1;
  localparam int MAX_READ_LATENCY = 4;
  localparam int LAT_CNT_W        = $clog2(MAX_READ_LATENCY + 1);
endpackage

// File: rtl/byte_write_ram.sv
// Single-port word RAM with per-byte write enables and a registered, write-first read.
module byte_write_ram
  import mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic                    clk_i,
  input  logic                    we_i,
  input  logic [BYTE_LANES-1:0]   byte_en_i,
  input  logic [AW-1:0]           addr_i,
  input  logic [BYTE_LANES*8-1:0] wdata_i,
  output logic [BYTE_LANES*8-1:0] rdata_o
);

  // Each lane is its own array so every lane maps onto a plain block RAM.
  // Write-first per lane: a written byte is visible on the read port right away.
  genvar gi;
  generate
    for (gi = 0; gi < BYTE_LANES; gi++) begin : g_lane
      logic [7:0] lane_mem [DEPTH_WORDS];
      logic [7:0] lane_rdata_reg;

      always_ff @(posedge clk_i) begin
        if (we_i && byte_en_i[gi]) begin
          lane_mem[addr_i] <= wdata_i[gi*8 +: 8];
          lane_rdata_reg   <= wdata_i[gi*8 +: 8];
        end else begin
          lane_rdata_reg   <= lane_mem[addr_i];
        end
      end

      assign rdata_o[gi*8 +: 8] = lane_rdata_reg;
    end
  endgenerate

endmodule

// File: rtl/data_memory_responder.sv
// Single-outstanding memory responder: accepts a load/store, commits stores at once,
// and returns the addressed word a fixed number of cycles later.
module data_memory_responder
  import mem_pkg::*;
#(
  parameter int DEPTH_WORDS  = 1024,
  parameter int READ_LATENCY = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_write_i,
  input  logic [3:0]  req_byte_en_i,
  input  logic [31:0] req_address_i,
  input  logic [31:0] req_wdata_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_error_o
);

  localparam int AW  = $clog2(DEPTH_WORDS);
  localparam int LAT = (READ_LATENCY < MIN_READ_LATENCY) ? MIN_READ_LATENCY :
                       (READ_LATENCY > MAX_READ_LATENCY) ? MAX_READ_LATENCY : READ_LATENCY;

  state_e                 state_reg;
  logic [LAT_CNT_W-1:0]   cnt_reg;
  logic [LAT_CNT_W-1:0]   cnt_next;
  logic [AW-1:0]          index_reg;
  logic                   error_reg;

  logic                   accept;
  logic                   in_range;
  logic                   ram_we;
  logic [AW-1:0]          ram_addr;
  logic [31:0]            ram_rdata;
  logic                   unused_addr_bits;

  assign unused_addr_bits = ^req_address_i[1:0];

  assign in_range    = (req_address_i[31:AW+2] == '0);
  assign req_ready_o = (state_reg == IDLE) && !rst_i;
  assign accept      = req_valid_i && req_ready_o;
  assign ram_we      = accept && req_write_i && in_range;
  assign cnt_next    = cnt_reg - 1'b1;

  // Point the RAM at the incoming request while idle so the write and the
  // read-back happen on the acceptance edge; afterwards hold the latched index.
  assign ram_addr = (state_reg == IDLE) ? req_address_i[AW+1:2] : index_reg;

  byte_write_ram #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_ram (
    .clk_i     (clk_i),
    .we_i      (ram_we),
    .byte_en_i (req_byte_en_i),
    .addr_i    (ram_addr),
    .wdata_i   (req_wdata_i),
    .rdata_o   (ram_rdata)
  );

  // The store is committed on the acceptance edge, so only the word index and
  // the range flag have to survive until the response.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      index_reg <= '0;
      error_reg <= 1'b0;
    end else begin
      unique case (state_reg)
        IDLE: begin
          if (req_valid_i) begin
            index_reg <= req_address_i[AW+1:2];
            error_reg <= !in_range;
            cnt_reg   <= LAT_CNT_W'(LAT - 1);
            state_reg <= (LAT == 1) ? RESP : WAIT;
          end
        end
        WAIT: begin
          cnt_reg <= cnt_next;
          if (cnt_next == '0) begin
            state_reg <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready_i) begin
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign rsp_valid_o = (state_reg == RESP);
  assign rsp_rdata_o = (rsp_valid_o && !error_reg) ? ram_rdata : '0;
  assign rsp_error_o = rsp_valid_o && error_reg;

endmodule

// File: tb/tb_data_memory_responder.sv
// Scoreboard bench: the driver queues expected responses, a negedge monitor checks them.
module tb_data_memory_responder;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          acc;
    string       tag;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        req_valid, req_write, rsp_ready;
  logic [3:0]  req_be;
  logic [31:0] req_addr, req_wdata;
  logic        req_ready_o, rsp_valid_o, rsp_error_o;
  logic [31:0] rsp_rdata_o;

  // Latency-sweep instances (index 0: latency 1, index 1: latency 4)
  logic        lv [2];
  logic        lw [2];
  logic [3:0]  lbe [2];
  logic [31:0] laddr [2];
  logic [31:0] lwd [2];
  logic        lready [2];
  logic        lrv [2];
  logic        lrr [2];
  logic [31:0] lrd [2];
  logic        lerr [2];

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   last_acc = 0;
  int   hs_cyc = 0;
  bit   in_resp = 0;
  exp_t cur;
  exp_t sb_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  data_memory_responder #(.DEPTH_WORDS(1024), .READ_LATENCY(2)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .req_valid_i(req_valid), .req_ready_o(req_ready_o), .req_write_i(req_write),
    .req_byte_en_i(req_be), .req_address_i(req_addr), .req_wdata_i(req_wdata),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready),
    .rsp_rdata_o(rsp_rdata_o), .rsp_error_o(rsp_error_o)
  );

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_lat
      data_memory_responder #(.DEPTH_WORDS(1024), .READ_LATENCY(gi == 0 ? 1 : 4)) u_lat (
        .clk_i(clk), .rst_i(rst_i),
        .req_valid_i(lv[gi]), .req_ready_o(lready[gi]), .req_write_i(lw[gi]),
        .req_byte_en_i(lbe[gi]), .req_address_i(laddr[gi]), .req_wdata_i(lwd[gi]),
        .rsp_valid_o(lrv[gi]), .rsp_ready_i(lrr[gi]),
        .rsp_rdata_o(lrd[gi]), .rsp_error_o(lerr[gi])
      );
    end
  endgenerate

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: compare every response against the head of the scoreboard
  always @(negedge clk) begin
    if (rst_i) begin
      in_resp = 0;
    end else if (rsp_valid_o) begin
      chk("ready_low_in_resp", 32'(req_ready_o), 32'd0);
      if (!in_resp) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_rsp: got rdata %h err %b, required no response", rsp_rdata_o, rsp_error_o);
          cur.rdata = rsp_rdata_o;
          cur.err   = rsp_error_o;
          cur.tag   = "unexpected";
        end else begin
          cur = sb_q.pop_front();
          chk({cur.tag, "_rdata"}, rsp_rdata_o, cur.rdata);
          chk({cur.tag, "_error"}, 32'(rsp_error_o), 32'(cur.err));
          chk({cur.tag, "_latency"}, 32'(cyc - cur.acc + 1), 32'd2);
          $display("rsp %s: rdata %h err %b", cur.tag, rsp_rdata_o, rsp_error_o);
        end
        in_resp = 1;
      end else begin
        chk({cur.tag, "_hold_rdata"}, rsp_rdata_o, cur.rdata);
        chk({cur.tag, "_hold_error"}, 32'(rsp_error_o), 32'(cur.err));
      end
      if (rsp_ready) begin
        in_resp = 0;
        hs_cyc  = cyc + 1;
      end
    end else begin
      chk("idle_rdata_zero", rsp_rdata_o, 32'd0);
      chk("idle_error_zero", 32'(rsp_error_o), 32'd0);
    end
  end

  task automatic issue(input logic w, input logic [3:0] be, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [31:0] exp_rd, input logic exp_err,
                       input bit expect_rsp, input string tag);
    bit   ok = 0;
    exp_t e;
    @(posedge clk);
    #1;
    req_write = w; req_be = be; req_addr = addr; req_wdata = wd; req_valid = 1'b1;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (req_ready_o) begin ok = 1; break; end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL %s_accept_timeout: req_ready_o stayed 0, required 1", tag);
      req_valid = 1'b0;
      return;
    end
    last_acc = cyc + 1;
    $display("req %s: write %b be %b addr %h wdata %h", tag, w, be, addr, wd);
    if (expect_rsp) begin
      e.rdata = exp_rd; e.err = exp_err; e.acc = last_acc; e.tag = tag;
      sb_q.push_back(e);
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    bit ok = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (sb_q.size() == 0 && !in_resp) begin ok = 1; break; end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL %s_rsp_timeout: %0d responses outstanding, required 0", tag, sb_q.size());
      sb_q.delete();
    end
  endtask

  task automatic lat_test(input int k, input int exp_lat, input logic w, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [31:0] exp_rd, input string tag);
    bit ok = 0;
    int n = 0;
    @(posedge clk);
    #1;
    lw[k] = w; lbe[k] = 4'hF; laddr[k] = addr; lwd[k] = wd; lv[k] = 1'b1;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      if (lready[k]) begin ok = 1; break; end
    end
    @(posedge clk);
    #1;
    lv[k] = 1'b0;
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL %s_accept_timeout: req_ready_o stayed 0, required 1", tag);
      return;
    end
    ok = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      n++;
      if (lrv[k]) begin ok = 1; break; end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL %s_rsp_timeout: rsp_valid_o stayed 0, required 1", tag);
      return;
    end
    $display("rsp %s: latency %0d rdata %h", tag, n, lrd[k]);
    chk({tag, "_latency"}, 32'(n), 32'(exp_lat));
    chk({tag, "_rdata"}, lrd[k], exp_rd);
    chk({tag, "_error"}, 32'(lerr[k]), 32'd0);
  endtask

  initial begin
    rst_i = 1'b1; req_valid = 0; req_write = 0; req_be = '0; req_addr = '0; req_wdata = '0;
    rsp_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      lv[k] = 0; lw[k] = 0; lbe[k] = '0; laddr[k] = '0; lwd[k] = '0; lrr[k] = 1'b1;
    end

    @(negedge clk);
    chk("reset_ready", 32'(req_ready_o), 32'd0);
    chk("reset_valid", 32'(rsp_valid_o), 32'd0);
    chk("reset_rdata", rsp_rdata_o, 32'd0);
    chk("reset_error", 32'(rsp_error_o), 32'd0);
    @(posedge clk);
    #1;
    rst_i = 1'b0;
    @(negedge clk);
    chk("post_reset_ready", 32'(req_ready_o), 32'd1);

    issue(1, 4'b1111, 32'h10, 32'hDEADBEEF, 32'hDEADBEEF, 0, 1, "st_10");
    issue(0, 4'b0000, 32'h10, 32'h0,        32'hDEADBEEF, 0, 1, "ld_10");
    issue(1, 4'b1111, 32'h20, 32'h11223344, 32'h11223344, 0, 1, "st_20");
    issue(1, 4'b1010, 32'h20, 32'hAA00BB00, 32'hAA22BB44, 0, 1, "st_20_be1010");
    issue(0, 4'b0000, 32'h20, 32'h0,        32'hAA22BB44, 0, 1, "ld_20");
    issue(0, 4'b0000, 32'h23, 32'h0,        32'hAA22BB44, 0, 1, "ld_23_unaligned");
    issue(1, 4'b1111, 32'h40, 32'h55667788, 32'h55667788, 0, 1, "st_40");
    issue(1, 4'b0000, 32'h40, 32'hFFFFFFFF, 32'h55667788, 0, 1, "st_40_be0000");
    issue(1, 4'b0101, 32'h40, 32'h00AA00BB, 32'h55AA77BB, 0, 1, "st_40_be0101");
    issue(0, 4'b0001, 32'h40, 32'h0,        32'h55AA77BB, 0, 1, "ld_40_be_ignored");
    issue(1, 4'b1111, 32'h0,  32'h0BADF00D, 32'h0BADF00D, 0, 1, "st_0");
    issue(1, 4'b1111, 32'h1000, 32'hFFFFFFFF, 32'h0, 1, 1, "st_1000_oor");
    issue(0, 4'b0000, 32'h1000, 32'h0,      32'h0,        1, 1, "ld_1000_oor");
    issue(0, 4'b0000, 32'h0,  32'h0,        32'h0BADF00D, 0, 1, "ld_0_after_oor");
    wait_done("basic");

    // Backpressure: hold the response 5 cycles while a second request waits
    rsp_ready = 1'b0;
    issue(0, 4'b0000, 32'h10, 32'h0, 32'hDEADBEEF, 0, 1, "ld_10_bp");
    fork
      begin
        for (int i = 0; i < 10; i++) begin
          @(negedge clk);
          if (rsp_valid_o) break;
        end
        repeat (5) @(posedge clk);
        #1;
        rsp_ready = 1'b1;
      end
      issue(0, 4'b0000, 32'h20, 32'h0, 32'hAA22BB44, 0, 1, "ld_20_after_bp");
    join
    chk("bubble_accept_cycle", 32'(last_acc), 32'(hs_cyc + 1));
    wait_done("backpressure");

    // Reset during WAIT of a store: no response, store stays written
    issue(1, 4'b1111, 32'h30, 32'hCAFEF00D, 32'h0, 0, 0, "st_30_reset");
    rst_i = 1'b1;
    @(posedge clk);
    #1;
    rst_i = 1'b0;
    @(negedge clk);
    chk("reset_midop_ready", 32'(req_ready_o), 32'd1);
    chk("reset_midop_valid", 32'(rsp_valid_o), 32'd0);
    repeat (4) @(negedge clk);
    issue(0, 4'b0000, 32'h30, 32'h0, 32'hCAFEF00D, 0, 1, "ld_30_after_reset");
    wait_done("reset_midop");

    lat_test(0, 1, 1, 32'h8, 32'h01020304, 32'h01020304, "lat1_st");
    lat_test(0, 1, 0, 32'h8, 32'h0,        32'h01020304, "lat1_ld");
    lat_test(1, 4, 1, 32'h8, 32'hA5A55A5A, 32'hA5A55A5A, "lat4_st");
    lat_test(1, 4, 0, 32'h8, 32'h0,        32'hA5A55A5A, "lat4_ld");

    repeat (4) @(negedge clk);
    chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete, required completion");
    $fatal(1, "timeout");
  end

endmodule
